// File: rtl/parking_access_frontend_pkg.sv
// Shared types and defaults for the parking access front end.
// Optional PARKING_SYNC_EN adds sensor synchronizers in parking_debounce.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;

  typedef logic [1:0] code_t;

  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT  = 1000;

endpackage

// File: rtl/parking_access_frontend_if.sv
// Sensor, keypad and gate-controller signals of the front end.
// Master drives raw sensors and keypad strobes; slave returns clean outputs.
interface parking_if
  import parking_pkg::*;
  ();

  logic  entry_raw;
  logic  exit_raw;
  logic  key_valid;
  code_t key_code;
  logic  key_enter;
  logic  key_clear;

  logic  entry_sensor;
  logic  exit_sensor;
  code_t password_1;
  code_t password_2;
  logic  pwd_valid;
  logic  busy;
  logic  timeout_pulse;

  modport master (
    output entry_raw, exit_raw,
    output key_valid, key_code,
    output key_enter, key_clear,
    input  entry_sensor, exit_sensor,
    input  password_1, password_2,
    input  pwd_valid, busy, timeout_pulse
  );

  modport slave (
    input  entry_raw, exit_raw,
    input  key_valid, key_code,
    input  key_enter, key_clear,
    output entry_sensor, exit_sensor,
    output password_1, password_2,
    output pwd_valid, busy, timeout_pulse
  );

endinterface

// File: rtl/parking_access_frontend_debounce.sv
// Per-sensor debounce; with PARKING_SYNC_EN defined the raw input
// first passes a two-flop synchronizer (adds 2 cycles latency).
module parking_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic raw_s;

`ifdef PARKING_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_in};
    end
  end

  assign raw_s = sync_q[1];
`else
  assign raw_s = raw_in;
`endif

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      clean_out <= 1'b0;
    end else if (raw_s == clean_out) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
      clean_out <= raw_s;
      cnt       <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/parking_access_frontend.sv
// Parking front end: sensor debounce plus keypad code entry FSM.
// Define PARKING_SYNC_EN to synchronize the raw sensors.
module parking_access_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_DEFAULT
) (
  input logic     clock,
  input logic     reset,
  parking_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  parking_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_entry_db (
    .clock    (clock),
    .reset    (reset),
    .raw_in   (bus.entry_raw),
    .clean_out(bus.entry_sensor)
  );

  parking_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_exit_db (
    .clock    (clock),
    .reset    (reset),
    .raw_in   (bus.exit_raw),
    .clean_out(bus.exit_sensor)
  );

  state_t        state_q, state_d;
  code_t         stage1_q, stage2_q;
  code_t         stage1_d, stage2_d;
  code_t         pw1_d, pw2_d;
  logic          pv_d, to_d, busy_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic do_clear, do_enter, do_valid;
  logic accepted, timed_out;

  // Highest-priority strobe present wins; if the state ignores it, nothing happens.
  assign do_clear = bus.key_clear;
  assign do_enter = !bus.key_clear && bus.key_enter
                 && (state_q == GOT2);
  assign do_valid = !bus.key_clear && !bus.key_enter
                 && bus.key_valid && (state_q != GOT2);
  assign accepted = do_clear || do_enter || do_valid;

  assign timed_out = (state_q != IDLE) && !accepted
                  && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      stage1_q          <= '0;
      stage2_q          <= '0;
      tcnt_q            <= '0;
      bus.password_1    <= '0;
      bus.password_2    <= '0;
      bus.pwd_valid     <= 1'b0;
      bus.busy          <= 1'b0;
      bus.timeout_pulse <= 1'b0;
    end else begin
      state_q           <= state_d;
      stage1_q          <= stage1_d;
      stage2_q          <= stage2_d;
      tcnt_q            <= tcnt_d;
      bus.password_1    <= pw1_d;
      bus.password_2    <= pw2_d;
      bus.pwd_valid     <= pv_d;
      bus.busy          <= busy_d;
      bus.timeout_pulse <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      do_clear:  state_d = IDLE;
      do_enter:  state_d = IDLE;
      do_valid:  state_d = (state_q == IDLE) ? GOT1 : GOT2;
      timed_out: state_d = IDLE;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    stage1_d = stage1_q;
    stage2_d = stage2_q;
    pw1_d    = bus.password_1;
    pw2_d    = bus.password_2;
    pv_d     = 1'b0;
    to_d     = 1'b0;
    unique case (1'b1)
      do_clear: begin
        stage1_d = '0;
        stage2_d = '0;
        pw1_d    = '0;
        pw2_d    = '0;
      end
      do_enter: begin
        pw1_d    = stage1_q;
        pw2_d    = stage2_q;
        pv_d     = 1'b1;
        stage1_d = '0;
        stage2_d = '0;
      end
      do_valid: begin
        if (state_q == IDLE) stage1_d = bus.key_code;
        else                 stage2_d = bus.key_code;
      end
      timed_out: begin
        stage1_d = '0;
        stage2_d = '0;
        to_d     = 1'b1;
      end
      default: begin
      end
    endcase
    busy_d = (state_d != IDLE);
    tcnt_d = (accepted || state_d == IDLE) ? '0 : tcnt_q + TW'(1);
  end

endmodule

// File: tb/tb_parking_access_frontend.sv
// Directed-vector bench for parking_access_frontend.
// Sensor latency expectations follow PARKING_SYNC_EN.
module tb_parking_access_frontend;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  parking_if bus ();

  parking_access_frontend #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

`ifdef PARKING_SYNC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       e;
    logic       cl;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       pv;
    logic       bz;
    logic       to;
  } vec_t;

  vec_t vecs [18];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c,
                       input logic e, input logic cl);
    bus.key_valid = v;
    bus.key_code  = c;
    bus.key_enter = e;
    bus.key_clear = cl;
  endtask

  task automatic key(input logic v, input logic [1:0] c,
                     input logic e, input logic cl);
    drive(v, c, e, cl);
    tick();
    drive(0, 2'b00, 0, 0);
  endtask

  task automatic chk_keys(input string tag, input logic [1:0] p1,
                          input logic [1:0] p2, input logic pv,
                          input logic bz, input logic to);
    chk({tag, "_pw1"}, 8'(bus.password_1), 8'(p1));
    chk({tag, "_pw2"}, 8'(bus.password_2), 8'(p2));
    chk({tag, "_pv"}, 8'(bus.pwd_valid), 8'(pv));
    chk({tag, "_busy"}, 8'(bus.busy), 8'(bz));
    chk({tag, "_to"}, 8'(bus.timeout_pulse), 8'(to));
  endtask

  initial begin
    //          v  c      e  cl  p1     p2     pv bz to
    vecs[0]  = '{1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1, 0};
    vecs[1]  = '{1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 0};
    vecs[2]  = '{0, 2'b00, 1, 0, 2'b01, 2'b10, 1, 0, 0};
    vecs[3]  = '{0, 2'b00, 0, 0, 2'b01, 2'b10, 0, 0, 0};
    vecs[4]  = '{0, 2'b00, 1, 0, 2'b01, 2'b10, 0, 0, 0};
    vecs[5]  = '{1, 2'b11, 0, 0, 2'b01, 2'b10, 0, 1, 0};
    vecs[6]  = '{0, 2'b00, 1, 0, 2'b01, 2'b10, 0, 1, 0};
    vecs[7]  = '{1, 2'b00, 0, 0, 2'b01, 2'b10, 0, 1, 0};
    vecs[8]  = '{1, 2'b11, 0, 0, 2'b01, 2'b10, 0, 1, 0};
    vecs[9]  = '{0, 2'b00, 1, 0, 2'b11, 2'b00, 1, 0, 0};
    vecs[10] = '{1, 2'b01, 0, 0, 2'b11, 2'b00, 0, 1, 0};
    vecs[11] = '{1, 2'b10, 0, 0, 2'b11, 2'b00, 0, 1, 0};
    vecs[12] = '{0, 2'b00, 1, 1, 2'b00, 2'b00, 0, 0, 0};
    vecs[13] = '{1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1, 0};
    vecs[14] = '{1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1, 0};
    vecs[15] = '{1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 1, 0};
    vecs[16] = '{0, 2'b00, 1, 0, 2'b01, 2'b10, 1, 0, 0};
    vecs[17] = '{1, 2'b10, 0, 1, 2'b00, 2'b00, 0, 0, 0};

    bus.entry_raw = 1'b0;
    bus.exit_raw  = 1'b0;
    drive(0, 2'b00, 0, 0);

    #12;
    chk_keys("rst", 2'b00, 2'b00, 0, 0, 0);
    chk("rst_entry", 8'(bus.entry_sensor), 8'd0);
    chk("rst_exit", 8'(bus.exit_sensor), 8'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].e, vecs[i].cl);
      tick();
      chk_keys($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2,
               vecs[i].pv, vecs[i].bz, vecs[i].to);
    end
    drive(0, 2'b00, 0, 0);

    key(1, 2'b01, 0, 0);
    key(1, 2'b10, 0, 0);
    key(0, 2'b00, 1, 0);
    chk_keys("tmo_pre", 2'b01, 2'b10, 1, 0, 0);
    key(1, 2'b11, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_keys($sformatf("tmo%0d", k), 2'b01, 2'b10, 0,
               k < 8, k == 8);
    end
    key(0, 2'b00, 1, 0);
    chk_keys("tmo_enter", 2'b01, 2'b10, 0, 0, 0);

    bus.entry_raw = 1'b1;
    repeat (3) tick();
    bus.entry_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("glitch%0d", k), 8'(bus.entry_sensor), 8'd0);
    end
    bus.entry_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("entry_rise%0d", k), 8'(bus.entry_sensor),
          8'(k >= LAT));
    end
    bus.exit_raw = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk($sformatf("exit_rise%0d", k), 8'(bus.exit_sensor),
          8'(k >= LAT));
    end
    bus.exit_raw = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk($sformatf("exit_fall%0d", k), 8'(bus.exit_sensor),
          8'(k < LAT));
    end

    key(1, 2'b01, 0, 0);
    key(1, 2'b10, 0, 0);
    key(0, 2'b00, 1, 0);
    key(1, 2'b11, 0, 0);
    chk_keys("pre_rst", 2'b01, 2'b10, 0, 1, 0);
    chk("pre_rst_entry", 8'(bus.entry_sensor), 8'd1);
    #3;
    reset = 1'b0;
    #1;
    chk_keys("mid_rst", 2'b00, 2'b00, 0, 0, 0);
    chk("mid_rst_entry", 8'(bus.entry_sensor), 8'd0);
    chk("mid_rst_exit", 8'(bus.exit_sensor), 8'd0);
    #1;
    reset = 1'b1;
    key(0, 2'b00, 1, 0);
    chk_keys("post_rst", 2'b00, 2'b00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_access_frontend.md
# parking_access_frontend

Input-conditioning stage that feeds the parking gate controller. It debounces the raw entry and exit sensors into clean levels. It also assembles two 2-bit keypad codes into the `password_1`/`password_2` pair, and presents that pair on an explicit enter key, with an inactivity timeout. All outputs are registered and drive the gate controller directly.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles a raw sensor needs before its output changes (≥1).
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between key events during entry (≥2).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low; clock clock.
- `entry_raw`  in  1  raw entry sensor.
- `exit_raw`  in  1  raw exit sensor.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid.
- `key_code`  in  2  keypad digit.
- `key_enter`  in  1  one-cycle strobe; submit the collected codes.
- `key_clear`  in  1  one-cycle strobe; abort and zero everything.
- `entry_sensor`  out  1  debounced entry level.
- `exit_sensor`  out  1  debounced exit level.
- `password_1`  out  2  presented first code.
- `password_2`  out  2  presented second code.
- `pwd_valid`  out  1  one-cycle pulse when new codes are presented.
- `busy`  out  1  high in `GOT1`/`GOT2`.
- `timeout_pulse`  out  1  one-cycle pulse on entry timeout.

## Operation
- **Reset values:** all outputs 0, FSM `IDLE`, staging registers 0, counters 0.
- **Debounce, per sensor:**
  - The counter increments while raw ≠ output and clears when raw = output.
  - When the count reaches `DEBOUNCE_CYCLES`, the output takes the raw value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never propagates.
- **FSM states:** `IDLE`, `GOT1`, `GOT2`.
  - `IDLE` + `key_valid`: `stage1 <= key_code`, go to `GOT1`.
  - `GOT1` + `key_valid`: `stage2 <= key_code`, go to `GOT2`.
  - `GOT2` + `key_enter`: presented registers take `stage1`/`stage2`, `pwd_valid` = 1 for one cycle, staging zeroed, go to `IDLE`.
  - `GOT2` + `key_valid`: ignored; extra digits are dropped.
  - `key_enter` in `IDLE` or `GOT1`: ignored, no state change.
- **Clear:** `key_clear` in any state zeroes staging and presented registers and goes to `IDLE`. The cycle after, `password_1`/`password_2` read 00.
- **Priority on simultaneous strobes:** `key_clear` > `key_enter` > `key_valid`. Lower-priority strobes in the same cycle are discarded.
- **Presented outputs:** hold their value until the next accepted `key_enter` or `key_clear`. Starting a new entry (`IDLE` → `GOT1`) does not alter them.
- **Timeout:**
  - The counter runs only in `GOT1`/`GOT2`, clears on any accepted strobe, and is held at 0 in `IDLE`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to `IDLE`, staging is zeroed and `timeout_pulse` = 1 for one cycle. Presented registers are unchanged.
- **Reset mid-entry:** immediate return to the reset values above, regardless of state.

## Timing
- Sensor latency: a raw change held stable appears on the output `DEBOUNCE_CYCLES`+1 edges after the raw change.
  - With `PARKING_SYNC_EN`, add 2 cycles.
- `key_valid` → state change: registered on the same edge.
- `key_enter` in `GOT2` → `password_*` and `pwd_valid` update on that edge, visible the following cycle.
- `busy` is a registered decode of the state.
- The timeout fires on the `TIMEOUT_CYCLES`-th consecutive edge without an accepted strobe in `GOT1`/`GOT2`.
- Strobes are sampled every cycle. Strobes held for several cycles count as multiple events.

## Configuration
- **`PARKING_SYNC_EN` defined:** `entry_raw` and `exit_raw` each pass through a two-flop synchronizer, reset to 0, before the debounce logic. Sensor latency grows by 2 cycles.
- **`PARKING_SYNC_EN` undefined:** the raw inputs feed debounce directly. Keypad inputs are never synchronized (same clock domain).

## Structure
- Package `parking_pkg` holds:
  - the FSM state enum (`IDLE`, `GOT1`, `GOT2`);
  - the 2-bit code typedef;
  - default values for `DEBOUNCE_CYCLES` and `TIMEOUT_CYCLES`.
- Sub-module `parking_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clock`, `reset`, `raw_in`, `clean_out`) holds the optional synchronizer and the counter. It is instantiated twice. The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
- `entry_raw` high for 3 cycles then low (`DEBOUNCE_CYCLES`=4) → `entry_sensor` stays 0. Held high for 10 cycles → `entry_sensor` 1 at edge 5 after the rise.
- `key_valid` with code 01, then 10, then `key_enter` → `password_1`=01, `password_2`=10, `pwd_valid` high exactly one cycle, `busy` back to 0.
- Code 01, then idle for `TIMEOUT_CYCLES` (set to 8) → `timeout_pulse` at cycle 8, `busy` 0, `password_*` keep previous values.
- `key_enter` and `key_clear` in the same cycle while in `GOT2` → no `pwd_valid`, `password_*` = 00, state `IDLE`.
- Codes 01, 10, then a third `key_valid` with 11, then `key_enter` → presented 01/10; the third digit is dropped.
- Reset asserted while in `GOT1` with presented 01/10 → all outputs 0 immediately; after release, `key_enter` alone produces no `pwd_valid`.
